// File: rtl/cache_refill_fsm_if.sv
// Merge-side read port of the refill engine: AR request, R data, read ownership.
// The master modport is the refill FSM, the slave modport is the AXI read merge.
interface cache_refill_fsm_if;
    logic        ren_o;
    logic        cache_ena_o;
    logic [31:0] araddr_o;
    logic        arvalid_o;
    logic        arready_i;
    logic [31:0] rdata_i;
    logic        rlast_i;
    logic        rvalid_i;
    logic        rready_o;

    modport master (
        output ren_o,
        output cache_ena_o,
        output araddr_o,
        output arvalid_o,
        input  arready_i,
        input  rdata_i,
        input  rlast_i,
        input  rvalid_i,
        output rready_o
    );

    modport slave (
        input  ren_o,
        input  cache_ena_o,
        input  araddr_o,
        input  arvalid_o,
        output arready_i,
        output rdata_i,
        output rlast_i,
        output rvalid_i,
        input  rready_o
    );
endinterface

// File: rtl/cache_refill_fsm.sv
// Per-cache read-miss engine: one AR request per miss, beats collected into a line buffer.
//
// state  | meaning
// IDLE   | waiting for miss_req_i; request fields latched on acceptance
// AR     | arvalid held until the merge accepts the address
// R      | collecting beats into the line buffer until rvalid with rlast
// DONE   | one-cycle completion pulse toward the cache
module cache_refill_fsm #(
    parameter int BURST_NUM = 7,
    parameter int CNT_W     = 3
) (
    input  logic                          clk,
    input  logic                          resetn,
    input  logic                          miss_req_i,
    input  logic [31:0]                   miss_addr_i,
    input  logic                          cache_ena_i,
    output logic                          refill_busy_o,
    output logic                          refill_done_o,
    output logic [32*(BURST_NUM+1)-1:0]   refill_line_o,
    cache_refill_fsm_if.master            bus
);

    localparam int WORDS = BURST_NUM + 1;
    localparam int OFF_W = $clog2(4 * WORDS);
    localparam logic [31:0]      LINE_MASK = ~((32'd1 << OFF_W) - 32'd1);
    localparam logic [CNT_W-1:0] CNT_MAX   = CNT_W'(WORDS - 1);

    typedef enum logic [1:0] {
        S_IDLE,
        S_AR,
        S_R,
        S_DONE
    } state_e;

    state_e                    state_q, state_d;
    logic [CNT_W-1:0]          cnt_q, cnt_d;
    logic [31:0]               addr_q, addr_d;
    logic                      cena_q, cena_d;
    logic [32*WORDS-1:0]       line_q, line_d;
    logic [CNT_W-1:0]          widx;

    always_ff @(posedge clk) begin
        if (!resetn) begin
            state_q <= S_IDLE;
            cnt_q   <= '0;
            addr_q  <= '0;
            cena_q  <= 1'b0;
            line_q  <= '0;
        end else begin
            state_q <= state_d;
            cnt_q   <= cnt_d;
            addr_q  <= addr_d;
            cena_q  <= cena_d;
            line_q  <= line_d;
        end
    end

    always_comb begin
        state_d = state_q;
        cnt_d   = cnt_q;
        addr_d  = addr_q;
        cena_d  = cena_q;
        line_d  = line_q;
        // Uncached reads always land in word 0 regardless of the counter.
        widx    = cena_q ? cnt_q : '0;
        case (state_q)
            S_IDLE: begin
                if (miss_req_i) begin
                    addr_d  = cache_ena_i ? (miss_addr_i & LINE_MASK) : miss_addr_i;
                    cena_d  = cache_ena_i;
                    cnt_d   = '0;
                    state_d = S_AR;
                end
            end
            S_AR: begin
                if (bus.arready_i) begin
                    state_d = S_R;
                end
            end
            S_R: begin
                if (bus.rvalid_i) begin
                    line_d[int'(widx)*32 +: 32] = bus.rdata_i;
                    // Saturate so an overlong burst keeps overwriting the last word.
                    if (cena_q && (cnt_q != CNT_MAX)) begin
                        cnt_d = cnt_q + CNT_W'(1);
                    end
                    if (bus.rlast_i) begin
                        state_d = S_DONE;
                    end
                end
            end
            S_DONE: begin
                state_d = S_IDLE;
            end
            default: begin
                state_d = S_IDLE;
            end
        endcase
    end

    assign refill_busy_o   = (state_q != S_IDLE);
    assign refill_done_o   = (state_q == S_DONE);
    assign refill_line_o   = line_q;
    assign bus.ren_o       = (state_q == S_AR) || (state_q == S_R);
    assign bus.arvalid_o   = (state_q == S_AR);
    assign bus.rready_o    = (state_q == S_R);
    assign bus.araddr_o    = addr_q;
    assign bus.cache_ena_o = cena_q;

endmodule

// File: tb/tb_cache_refill_fsm.sv
// Directed bench for cache_refill_fsm: cached, uncached, gapped, early-rlast,
// mid-burst reset and back-to-back refills against hand-derived line contents.
module tb_cache_refill_fsm;

    logic         clk;
    logic         resetn;
    logic         miss_req;
    logic [31:0]  miss_addr;
    logic         cache_ena;
    logic         busy;
    logic         done;
    logic [255:0] line;

    cache_refill_fsm_if bus ();

    cache_refill_fsm dut (
        .clk           (clk),
        .resetn        (resetn),
        .miss_req_i    (miss_req),
        .miss_addr_i   (miss_addr),
        .cache_ena_i   (cache_ena),
        .refill_busy_o (busy),
        .refill_done_o (done),
        .refill_line_o (line),
        .bus           (bus.master)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    int n_checks = 0;
    int n_pass   = 0;

    logic [31:0] beats [16];
    logic [31:0] exp_w [8];

    task automatic chk(input string tag, input logic [255:0] got, input logic [255:0] exp);
        n_checks++;
        if (got === exp) n_pass++;
        else $display("FAIL %s: got %h expected %h", tag, got, exp);
    endtask

    task automatic step();
        @(posedge clk);
        #1;
    endtask

    function automatic logic [255:0] exp_line();
        logic [255:0] p;
        for (int k = 0; k < 8; k++) p[32*k +: 32] = exp_w[k];
        return p;
    endfunction

    task automatic clear_model();
        for (int k = 0; k < 8; k++) exp_w[k] = 32'h0;
    endtask

    // One full refill. Leaves the bench one cycle after the done pulse (FSM in IDLE).
    task automatic refill(input logic [31:0] addr, input bit cena, input int ar_wait,
                          input int nbeats, input bit gap, input bit hold_req,
                          input logic [31:0] exp_addr);
        int idx;
        miss_req  = 1'b1;
        miss_addr = addr;
        cache_ena = cena;
        step();
        miss_addr = 32'h0;
        cache_ena = 1'b0;
        chk("ar_valid", 256'(bus.arvalid_o), 256'(1));
        chk("ar_addr", 256'(bus.araddr_o), 256'(exp_addr));
        chk("ar_cena", 256'(bus.cache_ena_o), 256'(cena));
        chk("ar_ren_busy", 256'({bus.ren_o, busy}), 256'(2'b11));
        for (int w = 0; w < ar_wait; w++) begin
            step();
            chk("ar_hold", 256'({bus.arvalid_o, bus.rready_o}), 256'(2'b10));
        end
        bus.arready_i = 1'b1;
        step();
        bus.arready_i = 1'b0;
        chk("r_entry", 256'({bus.arvalid_o, bus.rready_o, bus.ren_o}), 256'(3'b011));
        for (int i = 0; i < nbeats; i++) begin
            if (gap && i > 0) begin
                bus.rvalid_i = 1'b0;
                step();
                chk("gap_stay_r", 256'({bus.rready_o, done}), 256'(2'b10));
            end
            bus.rvalid_i = 1'b1;
            bus.rdata_i  = beats[i];
            bus.rlast_i  = (i == nbeats - 1);
            step();
            idx = cena ? ((i > 7) ? 7 : i) : 0;
            exp_w[idx] = beats[i];
            if (i != nbeats - 1) chk("no_early_done", 256'(done), 256'(0));
        end
        bus.rvalid_i = 1'b0;
        bus.rlast_i  = 1'b0;
        chk("done_pulse", 256'({done, bus.ren_o, bus.rready_o}), 256'(3'b100));
        chk("line", line, exp_line());
        if (!hold_req) miss_req = 1'b0;
        step();
        chk("idle_after_done", 256'({done, busy, bus.arvalid_o}), 256'(0));
    endtask

    initial begin
        resetn        = 1'b0;
        miss_req      = 1'b0;
        miss_addr     = 32'h0;
        cache_ena     = 1'b0;
        bus.arready_i = 1'b0;
        bus.rdata_i   = 32'h0;
        bus.rlast_i   = 1'b0;
        bus.rvalid_i  = 1'b0;
        clear_model();
        step();
        step();
        chk("rst_ctrl", 256'({busy, done, bus.ren_o, bus.cache_ena_o, bus.arvalid_o, bus.rready_o}), 256'(0));
        chk("rst_addr", 256'(bus.araddr_o), 256'(0));
        chk("rst_line", line, 256'(0));
        resetn = 1'b1;
        step();

        // Stray R traffic in IDLE must not touch the buffer or the state.
        bus.rvalid_i = 1'b1;
        bus.rlast_i  = 1'b1;
        bus.rdata_i  = 32'hCAFE_F00D;
        step();
        bus.rvalid_i = 1'b0;
        bus.rlast_i  = 1'b0;
        chk("idle_ignore_r", {224'(busy), line[31:0]}, {224'(0), 32'h0});

        // Cached refill, arready after 2 cycles.
        for (int k = 0; k < 8; k++) beats[k] = 32'h11 * (k + 1);
        refill(32'hBFC0_0014, 1'b1, 2, 8, 1'b0, 1'b0, 32'hBFC0_0000);
        chk("cached_line_lit", line,
            {32'h88, 32'h77, 32'h66, 32'h55, 32'h44, 32'h33, 32'h22, 32'h11});

        // Uncached single beat: only word 0 changes.
        beats[0] = 32'hDEAD_BEEF;
        refill(32'h1FAF_F012, 1'b0, 0, 1, 1'b0, 1'b0, 32'h1FAF_F012);
        chk("uncached_line_lit", line,
            {32'h88, 32'h77, 32'h66, 32'h55, 32'h44, 32'h33, 32'h22, 32'hDEAD_BEEF});

        // Gapped cached burst from a zeroed buffer.
        resetn = 1'b0;
        step();
        resetn = 1'b1;
        clear_model();
        chk("rst_line2", line, 256'(0));
        for (int k = 0; k < 8; k++) beats[k] = 32'h11 * (k + 1);
        refill(32'h0000_1234, 1'b1, 1, 8, 1'b1, 1'b0, 32'h0000_1220);
        chk("gapped_line_lit", line,
            {32'h88, 32'h77, 32'h66, 32'h55, 32'h44, 32'h33, 32'h22, 32'h11});

        // Early rlast after preloading all-ones.
        for (int k = 0; k < 8; k++) beats[k] = 32'hFFFF_FFFF;
        refill(32'h8000_0040, 1'b1, 0, 8, 1'b0, 1'b0, 32'h8000_0040);
        beats[0] = 32'hA0; beats[1] = 32'hA1; beats[2] = 32'hA2;
        refill(32'h8000_007C, 1'b1, 0, 3, 1'b0, 1'b0, 32'h8000_0060);
        chk("early_rlast_lit", line,
            {{5{32'hFFFF_FFFF}}, 32'hA2, 32'hA1, 32'hA0});

        // Overlong burst: beats past the line keep overwriting word 7.
        for (int k = 0; k < 10; k++) beats[k] = 32'h100 + k;
        refill(32'h0000_0000, 1'b1, 0, 10, 1'b0, 1'b0, 32'h0000_0000);
        chk("overlong_w7", 256'(line[255:224]), 256'(32'h109));

        // Reset after beat 4 of a cached burst.
        miss_req  = 1'b1;
        miss_addr = 32'h4000_0010;
        cache_ena = 1'b1;
        step();
        miss_req      = 1'b0;
        bus.arready_i = 1'b1;
        step();
        bus.arready_i = 1'b0;
        for (int i = 0; i < 4; i++) begin
            bus.rvalid_i = 1'b1;
            bus.rdata_i  = 32'h5000 + i;
            step();
        end
        bus.rvalid_i = 1'b0;
        resetn = 1'b0;
        step();
        resetn = 1'b1;
        clear_model();
        chk("midrst_ctrl", 256'({busy, done, bus.ren_o, bus.cache_ena_o, bus.arvalid_o, bus.rready_o}), 256'(0));
        chk("midrst_addr_line", {line[255:32], bus.araddr_o}, 256'(0));
        step();
        chk("midrst_no_done", 256'({done, busy}), 256'(0));
        for (int k = 0; k < 8; k++) beats[k] = 32'hC0 + k;
        refill(32'h4000_0010, 1'b1, 0, 8, 1'b0, 1'b0, 32'h4000_0000);

        // Back-to-back: request held through done, second AR two cycles after it.
        for (int k = 0; k < 8; k++) beats[k] = 32'hD0 + k;
        refill(32'h2000_0104, 1'b1, 0, 8, 1'b0, 1'b1, 32'h2000_0100);
        for (int k = 0; k < 8; k++) beats[k] = 32'hE0 + k;
        refill(32'h2000_0A3C, 1'b1, 0, 8, 1'b0, 1'b0, 32'h2000_0A20);
        chk("b2b_line_w0_w7", 256'({line[255:224], line[31:0]}), 256'({32'hE7, 32'hE0}));

        $display("%0d/%0d checks passed", n_pass, n_checks);
        $finish;
    end

endmodule
